// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit saturating counters for the fetch stage.
// Combinational lookup, one registered resolve-stage update per cycle, saturating mispredict counter.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned MODE    = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      lookup_pc,
  output logic             predict_taken,
  output logic [31:0]      predict_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];
  logic             jmp_q    [ENTRIES];
  logic [CNT_W-1:0] mcnt_q;
  logic [CNT_W-1:0] mcnt_d;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  logic             wr_en;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      target_d;
  logic [1:0]       cnt_d;
  logic             jmp_d;

  // Byte-offset bits of both PCs carry no information for word-aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup reads the table as it stands; a same-cycle update is not bypassed.
  always_comb begin
    predict_taken = 1'b0;
    if (MODE != 0) begin
      predict_taken = lk_hit && (jmp_q[lk_idx] || cnt_q[lk_idx][1]);
    end
    predict_target = predict_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
  end

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  assign mcnt_d = (mispredict && (mcnt_q != {CNT_W{1'b1}})) ? mcnt_q + CNT_W'(1) : mcnt_q;
  assign mispredict_count = mcnt_q;

  // Next contents of the entry addressed by upd_pc; written only when wr_en is set.
  always_comb begin
    wr_en    = 1'b0;
    valid_d  = valid_q[upd_idx];
    tag_d    = tag_q[upd_idx];
    target_d = target_q[upd_idx];
    cnt_d    = cnt_q[upd_idx];
    jmp_d    = jmp_q[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          target_d = upd_target;
          cnt_d    = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'd1;
        end else begin
          cnt_d    = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'd1;
        end
        if (upd_is_jump) begin
          jmp_d = 1'b1;
          cnt_d = 2'b11;
        end
      end else if (upd_taken) begin
        wr_en    = 1'b1;
        valid_d  = 1'b1;
        tag_d    = upd_tag;
        target_d = upd_target;
        jmp_d    = upd_is_jump;
        cnt_d    = upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
        jmp_q[i]    <= 1'b0;
      end
      mcnt_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[upd_idx]  <= valid_d;
        tag_q[upd_idx]    <= tag_d;
        target_q[upd_idx] <= target_d;
        cnt_q[upd_idx]    <= cnt_d;
        jmp_q[upd_idx]    <= jmp_d;
      end
      mcnt_q <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: a bimodal predictor and a static not-taken predictor with a 4-bit
// counter see identical directed stimulus; a negedge monitor checks queued expectations.
module tb_branch_predictor;

  logic        CLK;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        tk0, tk1, misp0, misp1;
  logic [31:0] tgt0, tgt1, cnt_o0;
  logic [3:0]  cnt_o1;

  branch_predictor #(.ENTRIES(16), .MODE(1), .CNT_W(32)) dut0 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .predict_taken(tk0), .predict_target(tgt0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(misp0), .mispredict_count(cnt_o0)
  );

  branch_predictor #(.ENTRIES(16), .MODE(0), .CNT_W(4)) dut1 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .predict_taken(tk1), .predict_target(tgt1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(misp1), .mispredict_count(cnt_o1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic        tk;
    logic [31:0] tgt;
    logic        misp;
    logic [31:0] c0;
    logic [31:0] tgt1;
    logic [31:0] c1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt0   = 0;
  int   cnt1   = 0;

  task automatic cmp(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare both DUTs.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.nm, "taken0",  32'(tk0),    32'(e.tk));
      cmp(e.nm, "target0", tgt0,        e.tgt);
      cmp(e.nm, "misp0",   32'(misp0),  32'(e.misp));
      cmp(e.nm, "count0",  cnt_o0,      e.c0);
      cmp(e.nm, "taken1",  32'(tk1),    32'd0);
      cmp(e.nm, "target1", tgt1,        e.tgt1);
      cmp(e.nm, "misp1",   32'(misp1),  32'(e.misp));
      cmp(e.nm, "count1",  32'(cnt_o1), e.c1);
    end
  end

  // Drive one cycle of inputs and queue what both DUTs must show during it.
  task automatic step(input string nm, input logic rst, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ujmp,
                      input logic utk, input logic [31:0] utgt,
                      input logic uptk, input logic [31:0] uptgt,
                      input logic etk, input logic [31:0] etgt, input logic emisp);
    exp_t e;
    nRST            = rst;
    lookup_pc       = lpc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_is_jump     = ujmp;
    upd_taken       = utk;
    upd_target      = utgt;
    upd_pred_taken  = uptk;
    upd_pred_target = uptgt;
    if (!rst) begin
      cnt0 = 0;
      cnt1 = 0;
    end
    e.nm   = nm;
    e.tk   = etk;
    e.tgt  = etgt;
    e.misp = emisp;
    e.c0   = 32'(cnt0);
    e.tgt1 = lpc + 32'd4;
    e.c1   = 32'(cnt1);
    q.push_back(e);
    if (rst && emisp) begin
      cnt0++;
      if (cnt1 < 15) cnt1++;
    end
    @(posedge CLK);
    #1;
  endtask

  // Lookup only; the idle update bus carries junk that must be ignored.
  task automatic look(input string nm, input logic [31:0] lpc, input logic etk, input logic [31:0] etgt);
    step(nm, 1'b1, lpc, 1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom,
         1'($urandom), $urandom, etk, etgt, 1'b0);
  endtask

  task automatic upd(input string nm, input logic [31:0] lpc, input logic [31:0] upc,
                     input logic ujmp, input logic utk, input logic [31:0] utgt,
                     input logic uptk, input logic [31:0] uptgt,
                     input logic etk, input logic [31:0] etgt, input logic emisp);
    step(nm, 1'b1, lpc, 1'b1, upc, ujmp, utk, utgt, uptk, uptgt, etk, etgt, emisp);
  endtask

  initial begin
    nRST = 1'b0;
    lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    repeat (2) @(posedge CLK);
    #1;

    step("rst", 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
    look("post_rst", 32'h40, 1'b0, 32'h44);

    // Allocation; same-cycle lookup still sees the empty entry.
    upd("alloc40", 32'h40, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0, 32'h44, 1'b1);
    look("hit40", 32'h40, 1'b1, 32'h100);
    for (int i = 0; i < 3; i++)
      upd("inc40", 32'h40, 32'h40, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
    upd("dec40a", 32'h40, 32'h40, 1'b0, 1'b0, 32'h44, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
    look("still_tk40", 32'h40, 1'b1, 32'h100);
    upd("dec40b", 32'h40, 32'h40, 1'b0, 1'b0, 32'h44, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
    look("not_tk40", 32'h40, 1'b0, 32'h44);

    // Aliasing at index 0 and target replacement on a hit.
    upd("alloc80", 32'h80, 32'h80, 1'b0, 1'b1, 32'h200, 1'b0, 32'h84, 1'b0, 32'h84, 1'b1);
    look("alias40", 32'h40, 1'b0, 32'h44);
    look("hit80", 32'h80, 1'b1, 32'h200);
    upd("tgt80", 32'h80, 32'h80, 1'b0, 1'b1, 32'h240, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1);
    look("newtgt80", 32'h80, 1'b1, 32'h240);

    // Jumps stay predicted taken regardless of later not-taken updates.
    upd("jal20", 32'h20, 32'h20, 1'b1, 1'b1, 32'h300, 1'b0, 32'h24, 1'b0, 32'h24, 1'b1);
    look("jal20_hit", 32'h20, 1'b1, 32'h300);
    for (int i = 0; i < 5; i++)
      upd("jal20_nt", 32'h20, 32'h20, 1'b0, 1'b0, 32'h24, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1);
    look("jal20_sticky", 32'h20, 1'b1, 32'h300);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Miss + not-taken mispredicts: table untouched, counters climb (4-bit one saturates).
    for (int i = 0; i < 6; i++)
      upd("sat", 32'h10, 32'h10, 1'b0, 1'b0, 32'h14, 1'b1, 32'h500, 1'b0, 32'h14, 1'b1);
    look("sat_hold", 32'h10, 1'b0, 32'h14);
    look("sat_hold2", 32'h80, 1'b1, 32'h240);

    // Reset asserted with a valid update pending: nothing of it may land.
    step("rst_mid", 1'b0, 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h500, 1'b0, 32'h84,
         1'b0, 32'h84, 1'b1);
    look("post_rst80", 32'h80, 1'b0, 32'h84);
    look("post_rst40", 32'h40, 1'b0, 32'h44);
    look("post_rst20", 32'h20, 1'b0, 32'h24);

    repeat (2) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
